// File: rtl/alu_op_issuer.sv
// Initiator-side sequencer for the Total_ALU datapath: issues one operation at a time,
// waits out the ALU/divider latency and returns the sampled result(s) over a valid/ready response.
module alu_op_issuer #(
  parameter int          DIV_CYCLES = 32,
  parameter int          RES_LAT    = 2,
  parameter logic [5:0]  SIG_DIVU   = 6'd27,
  parameter logic [5:0]  SIG_MFHI   = 6'd16,
  parameter logic [5:0]  SIG_MFLO   = 6'd18,
  parameter logic [5:0]  SIG_IDLE   = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [5:0]  signal,
  input  logic [31:0] dataOut,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_div,
  output logic        rsp_dbz,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, EXEC, DIV, RDHI, RDLO, RESP} state_t;

  localparam int MAX_CYC = (DIV_CYCLES > RES_LAT) ? DIV_CYCLES : RES_LAT;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(RES_LAT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          dbz;
  logic          cnt_done;

  assign cnt_done  = (cnt == '0);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // NOTE: every state register uses <= so all reads in this block see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dbz       <= 1'b0;
      dataA     <= '0;
      dataB     <= '0;
      signal    <= SIG_IDLE;
      rsp_valid <= 1'b0;
      rsp_lo    <= '0;
      rsp_hi    <= '0;
      rsp_div   <= 1'b0;
      rsp_dbz   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            dataA  <= req_a;
            dataB  <= req_b;
            signal <= req_op;
            dbz    <= (req_b == '0);
            if (req_op == SIG_DIVU) begin
              state <= DIV;
              cnt   <= DIV_LOAD;
            end else begin
              state <= EXEC;
              cnt   <= LAT_LOAD;
            end
          end
        end
        EXEC: begin
          if (cnt_done) begin
            rsp_lo    <= dataOut;
            rsp_hi    <= '0;
            rsp_div   <= 1'b0;
            rsp_dbz   <= 1'b0;
            rsp_valid <= 1'b1;
            signal    <= SIG_IDLE;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Operands stay frozen through DIV/RDHI/RDLO; the divider reads them every cycle.
        DIV: begin
          if (cnt_done) begin
            signal <= SIG_MFHI;
            cnt    <= LAT_LOAD;
            state  <= RDHI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RDHI: begin
          if (cnt_done) begin
            rsp_hi <= dataOut;
            signal <= SIG_MFLO;
            cnt    <= LAT_LOAD;
            state  <= RDLO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RDLO: begin
          if (cnt_done) begin
            rsp_lo    <= dataOut;
            rsp_div   <= 1'b1;
            rsp_dbz   <= dbz;
            rsp_valid <= 1'b1;
            signal    <= SIG_IDLE;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: a small behavioural ALU (registered dataOut, 32-edge divider)
// answers the issuer; responses, latencies and signal sequences are checked against hand values.
module tb_alu_op_issuer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] dataA, dataB, dataOut;
  logic [5:0]  signal;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_lo, rsp_hi;
  logic        rsp_div, rsp_dbz, busy;

  int n_vec = 0;
  int n_err = 0;

  alu_op_issuer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .dataA(dataA), .dataB(dataB), .signal(signal), .dataOut(dataOut),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .rsp_div(rsp_div), .rsp_dbz(rsp_dbz), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU model: one-edge result register; HI/LO valid only after 32 consecutive DIVU edges.
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;
  logic [31:0] hi_q = 32'hDEAD_BEEF;
  logic [31:0] lo_q = 32'hDEAD_BEEF;
  int          div_run = 0;

  always @(posedge clk) begin
    if (signal == 6'd27) begin
      if (div_run + 1 == 32) begin
        hi_q <= (dataB == 0) ? dataA : dataA % dataB;
        lo_q <= (dataB == 0) ? 32'hFFFF_FFFF : dataA / dataB;
      end else begin
        hi_q <= BAD;
        lo_q <= BAD;
      end
      div_run <= div_run + 1;
    end else begin
      div_run <= 0;
    end
    case (signal)
      6'd32:   dataOut <= dataA + dataB;
      6'd16:   dataOut <= hi_q;
      6'd18:   dataOut <= lo_q;
      default: dataOut <= 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [5:0]  sig_log[$];
  logic [31:0] hold_a, hold_b;
  logic        ops_stable;
  logic        ready_low;
  int          lat;

  // Present a request at a negedge; it is accepted on the following posedge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    hold_a = a; hold_b = b;
    sig_log.delete();
    sig_log.push_back(signal);
    ops_stable = 1'b1;
    ready_low  = 1'b1;
  endtask

  // Count edges after the accept edge until rsp_valid rises, bounded.
  task automatic wait_rsp();
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (signal !== sig_log[$]) sig_log.push_back(signal);
      if (dataA !== hold_a || dataB !== hold_b) ops_stable = 1'b0;
      if (!rsp_valid && req_ready !== 1'b0) ready_low = 1'b0;
    end
  endtask

  logic [31:0] cap_lo, cap_hi;
  logic        held;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_signal", 32'(signal), 32'd0);
    check("rst_dataA", dataA, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);

    // ADD 5+7 with consumer ready
    rsp_ready = 1'b1;
    issue(6'd32, 32'd5, 32'd7);
    check("add_busy", 32'(busy), 32'd1);
    wait_rsp();
    check("add_latency", lat, 32'd2);
    check("add_lo", rsp_lo, 32'd12);
    check("add_hi", rsp_hi, 32'd0);
    check("add_div", 32'(rsp_div), 32'd0);
    check("add_sig_resp", 32'(signal), 32'd0);
    @(negedge clk);
    check("add_done_valid", 32'(rsp_valid), 32'd0);
    check("add_done_ready", 32'(req_ready), 32'd1);

    // DIVU 100/7, request held with other operands, response back-pressured
    rsp_ready = 1'b0;
    issue(6'd27, 32'd100, 32'd7);
    req_valid = 1'b1; req_op = 6'd32; req_a = 32'd55; req_b = 32'd66;
    wait_rsp();
    check("divu_latency", lat, 32'd36);
    check("divu_lo", rsp_lo, 32'd14);
    check("divu_hi", rsp_hi, 32'd2);
    check("divu_div", 32'(rsp_div), 32'd1);
    check("divu_dbz", 32'(rsp_dbz), 32'd0);
    check("divu_sig_count", sig_log.size(), 32'd4);
    if (sig_log.size() == 4) begin
      check("divu_sig0", 32'(sig_log[0]), 32'd27);
      check("divu_sig1", 32'(sig_log[1]), 32'd16);
      check("divu_sig2", 32'(sig_log[2]), 32'd18);
      check("divu_sig3", 32'(sig_log[3]), 32'd0);
    end
    check("divu_ops_stable", 32'(ops_stable), 32'd1);
    check("divu_ready_low", 32'(ready_low), 32'd1);
    cap_lo = rsp_lo; cap_hi = rsp_hi; held = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_lo !== cap_lo || rsp_hi !== cap_hi) held = 1'b0;
    end
    check("resp_hold_5", 32'(held), 32'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hs_valid", 32'(rsp_valid), 32'd0);
    check("hs_idle", 32'(busy), 32'd0);
    check("hs_dataA_kept", dataA, 32'd100);

    // DIVU by zero
    issue(6'd27, 32'd9, 32'd0);
    wait_rsp();
    check("dbz_latency", lat, 32'd36);
    check("dbz_flag", 32'(rsp_dbz), 32'd1);
    check("dbz_div", 32'(rsp_div), 32'd1);
    check("dbz_hi", rsp_hi, 32'd9);
    check("dbz_lo", rsp_lo, 32'hFFFF_FFFF);
    @(negedge clk);

    // Reset at edge 10 of a DIVU
    issue(6'd27, 32'd50, 32'd5);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_signal", 32'(signal), 32'd0);
    check("mid_rst_dataA", dataA, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    issue(6'd32, 32'd1, 32'd1);
    wait_rsp();
    check("post_rst_latency", lat, 32'd2);
    check("post_rst_lo", rsp_lo, 32'd2);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
